// File: rtl/ex_ctrl_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ex_ctrl_stage                                                    |
// | Purpose : ID/EX stage - decodes a MIPS-subset instruction into an ALU      |
// |           command plus operands and registers them behind valid/ready.     |
// |           Define EX_CTRL_SKID_EN for a one-entry skid buffer with a        |
// |           registered in_ready.                                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ex_ctrl_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        ex_cmd,
   output logic [DATA_W-1:0] input1,
   output logic [DATA_W-1:0] input2,
   output logic [DATA_W-1:0] store_data,
   output logic [REG_AW-1:0] dst,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              branch_eq,
   output logic              branch_ne,
   output logic              illegal
);

   localparam logic [3:0] c_CMD_ADD = 4'b0000;
   localparam logic [3:0] c_CMD_SUB = 4'b0001;
   localparam logic [3:0] c_CMD_AND = 4'b0010;
   localparam logic [3:0] c_CMD_OR  = 4'b0011;
   localparam logic [3:0] c_CMD_NOR = 4'b0100;
   localparam logic [3:0] c_CMD_XOR = 4'b0101;
   localparam logic [3:0] c_CMD_SLL = 4'b0110;
   localparam logic [3:0] c_CMD_SRL = 4'b1000;
   localparam logic [3:0] c_CMD_SRA = 4'b1001;

   typedef struct packed {
      logic [3:0]        cmd;
      logic [DATA_W-1:0] in1;
      logic [DATA_W-1:0] in2;
      logic [DATA_W-1:0] sd;
      logic [REG_AW-1:0] dst;
      logic              rw;
      logic              mr;
      logic              mw;
      logic              beq;
      logic              bne;
      logic              ill;
   } bundle_t;

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [15:0] w_imm;
   logic [DATA_W-1:0] w_imm_sx;
   logic [DATA_W-1:0] w_imm_zx;
   logic [DATA_W-1:0] w_shamt;
   logic [DATA_W-1:0] w_rs_amt;
   logic        w_unused_rs_field;
   bundle_t     w_dec;
   bundle_t     r_main;
   logic        r_valid;
   logic        w_accept;

   assign w_op     = instr[31:26];
   assign w_funct  = instr[5:0];
   assign w_imm    = instr[15:0];
   assign w_imm_sx = {{(DATA_W-16){w_imm[15]}}, w_imm};
   assign w_imm_zx = {{(DATA_W-16){1'b0}}, w_imm};
   assign w_shamt  = {{(DATA_W-5){1'b0}}, instr[10:6]};
   assign w_rs_amt = {{(DATA_W-5){1'b0}}, rs_data[4:0]};
   // rs operand arrives already read from the register file
   assign w_unused_rs_field = ^instr[25:21];

   always_comb begin
      w_dec     = '0;
      w_dec.sd  = rt_data;
      w_dec.in1 = rs_data;
      w_dec.in2 = rt_data;
      w_dec.dst = REG_AW'(instr[20:16]);
      case (w_op)
         6'h00: begin
            w_dec.dst = REG_AW'(instr[15:11]);
            w_dec.rw  = 1'b1;
            case (w_funct)
               6'h20, 6'h21: w_dec.cmd = c_CMD_ADD;
               6'h22, 6'h23: w_dec.cmd = c_CMD_SUB;
               6'h24:        w_dec.cmd = c_CMD_AND;
               6'h25:        w_dec.cmd = c_CMD_OR;
               6'h26:        w_dec.cmd = c_CMD_XOR;
               6'h27:        w_dec.cmd = c_CMD_NOR;
               6'h00: begin w_dec.cmd = c_CMD_SLL; w_dec.in1 = rt_data; w_dec.in2 = w_shamt;  end
               6'h02: begin w_dec.cmd = c_CMD_SRL; w_dec.in1 = rt_data; w_dec.in2 = w_shamt;  end
               6'h03: begin w_dec.cmd = c_CMD_SRA; w_dec.in1 = rt_data; w_dec.in2 = w_shamt;  end
               6'h04: begin w_dec.cmd = c_CMD_SLL; w_dec.in1 = rt_data; w_dec.in2 = w_rs_amt; end
               6'h06: begin w_dec.cmd = c_CMD_SRL; w_dec.in1 = rt_data; w_dec.in2 = w_rs_amt; end
               6'h07: begin w_dec.cmd = c_CMD_SRA; w_dec.in1 = rt_data; w_dec.in2 = w_rs_amt; end
               default:      w_dec.ill = 1'b1;
            endcase
         end
         6'h08, 6'h09: begin w_dec.cmd = c_CMD_ADD; w_dec.in2 = w_imm_sx; w_dec.rw = 1'b1; end
         6'h0C: begin w_dec.cmd = c_CMD_AND; w_dec.in2 = w_imm_zx; w_dec.rw = 1'b1; end
         6'h0D: begin w_dec.cmd = c_CMD_OR;  w_dec.in2 = w_imm_zx; w_dec.rw = 1'b1; end
         6'h0E: begin w_dec.cmd = c_CMD_XOR; w_dec.in2 = w_imm_zx; w_dec.rw = 1'b1; end
         6'h23: begin w_dec.cmd = c_CMD_ADD; w_dec.in2 = w_imm_sx; w_dec.rw = 1'b1; w_dec.mr = 1'b1; end
         6'h2B: begin w_dec.cmd = c_CMD_ADD; w_dec.in2 = w_imm_sx; w_dec.mw = 1'b1; end
         6'h04: begin w_dec.cmd = c_CMD_SUB; w_dec.beq = 1'b1; end
         6'h05: begin w_dec.cmd = c_CMD_SUB; w_dec.bne = 1'b1; end
         6'h0F: begin
            w_dec.cmd        = c_CMD_ADD;
            w_dec.in1        = '0;
            w_dec.in1[31:16] = w_imm;
            w_dec.in2        = '0;
            w_dec.rw         = 1'b1;
         end
         default: w_dec.ill = 1'b1;
      endcase
      if (w_dec.ill) begin
         w_dec.cmd = c_CMD_ADD;
         w_dec.rw  = 1'b0;
         w_dec.mr  = 1'b0;
         w_dec.mw  = 1'b0;
         w_dec.beq = 1'b0;
         w_dec.bne = 1'b0;
      end
      // $0 is hardwired; never schedule a writeback to it
      if (w_dec.dst == '0)
         w_dec.rw = 1'b0;
   end

`ifdef EX_CTRL_SKID_EN
   bundle_t r_skid;
   logic    r_skid_valid;

   assign in_ready = !r_skid_valid;
   assign w_accept = in_valid && in_ready && !flush;

   // Skid only fills while the main entry is stalled, and drains first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_main       <= '0;
         r_skid_valid <= 1'b0;
         r_skid       <= '0;
      end else if (flush) begin
         r_valid      <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (r_valid && !out_ready) begin
         if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
         end
      end else if (r_skid_valid) begin
         r_main       <= r_skid;
         r_valid      <= 1'b1;
         r_skid_valid <= 1'b0;
      end else if (w_accept) begin
         r_main  <= w_dec;
         r_valid <= 1'b1;
      end else begin
         r_valid <= 1'b0;
      end
   end
`else
   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_main  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_main  <= w_dec;
         r_valid <= 1'b1;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end
`endif

   assign out_valid  = r_valid;
   assign ex_cmd     = r_main.cmd;
   assign input1     = r_main.in1;
   assign input2     = r_main.in2;
   assign store_data = r_main.sd;
   assign dst        = r_main.dst;
   assign reg_write  = r_main.rw;
   assign mem_read   = r_main.mr;
   assign mem_write  = r_main.mw;
   assign branch_eq  = r_main.beq;
   assign branch_ne  = r_main.bne;
   assign illegal    = r_main.ill;

endmodule
`default_nettype wire
